prm_edge_mask_collector: RTL

- Sits directly downstream of the PRM obstacle edge-check array, the bank of per-edge combinational checkers. Each checker takes the 15-bit obstacle code A..O and drives one edge_mask bit.
- The block registers each incoming obstacle code and drives that registered code onto the checker array inputs. One cycle later it samples the array's edge_mask vector.
- It ORs the sampled masks across all obstacles of a frame. At frame end it streams the accumulated blocked-edge bitmap to the graph-search stage in WORD_W-bit words over a valid/ready handshake.

---
 rtl/prm_edge_pkg.sv | 17 +
 rtl/prm_bitmap_serializer.sv | 121 ++++++++++++
 rtl/prm_edge_mask_collector.sv | 82 ++++++++
 3 files changed

// File: rtl/prm_edge_pkg.sv
// rtl/prm_edge_pkg.sv - shared state type, constants and word-count helper for the PRM edge-mask collector
package prm_edge_pkg;

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_EMIT    = 1'b1
    } state_t;

    localparam int PRM_CODE_W    = 15;
    localparam int PRM_NUM_EDGES = 1024;
    localparam int PRM_WORD_W    = 32;

    function automatic int num_words(input int num_edges, input int word_w);
        return (num_edges + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/prm_bitmap_serializer.sv
// rtl/prm_bitmap_serializer.sv - accumulates sampled edge masks and streams the bitmap as zero-padded words
// Optional blocked-edge popcount output under PRM_EDGE_CNT_EN.
module prm_bitmap_serializer
    import prm_edge_pkg::*;
#(
    parameter int NUM_EDGES = PRM_NUM_EDGES,
    parameter int WORD_W    = PRM_WORD_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample,
    input  logic                         sample_last,
    input  logic [NUM_EDGES-1:0]         edge_mask_vec,
    output logic                         emitting,
    output logic                         done,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WORD_W-1:0]            out_data,
    output logic                         out_last
`ifdef PRM_EDGE_CNT_EN
    ,
    output logic [$clog2(NUM_EDGES+1)-1:0] blocked_cnt
`endif
);

    localparam int NUM_WORDS = num_words(NUM_EDGES, WORD_W);
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int PAD_W     = NUM_WORDS * WORD_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_t               state;
    state_t               state_nxt;
    logic [NUM_EDGES-1:0] blocked_q;
    logic [NUM_EDGES-1:0] merged;
    logic [IDX_W-1:0]     word_idx;
    logic [PAD_W-1:0]     padded;
    logic                 at_last;
    logic                 enter_emit;

    assign merged     = blocked_q | edge_mask_vec;
    assign at_last    = (word_idx == LAST_IDX);
    assign enter_emit = (state == S_COLLECT) && sample && sample_last;

    always_comb begin
        state_nxt = state;
        emitting  = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            S_COLLECT: begin
                if (sample && sample_last) begin
                    state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                emitting  = 1'b1;
                out_valid = 1'b1;
                out_last  = at_last;
                if (out_ready && at_last) begin
                    done      = 1'b1;
                    state_nxt = S_COLLECT;
                end
            end
            default: state_nxt = S_COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_COLLECT;
            blocked_q <= '0;
            word_idx  <= '0;
        end else begin
            state <= state_nxt;
            if (done) begin
                blocked_q <= '0;
            end else if (sample) begin
                blocked_q <= merged;
            end
            if (done) begin
                word_idx <= '0;
            end else if ((state == S_EMIT) && out_ready) begin
                word_idx <= word_idx + 1'b1;
            end
        end
    end

    // Edges past NUM_EDGES in the final word read as zero.
    always_comb begin
        padded                 = '0;
        padded[NUM_EDGES-1:0]  = blocked_q;
    end

    assign out_data = out_valid ? padded[int'(word_idx) * WORD_W +: WORD_W] : '0;

`ifdef PRM_EDGE_CNT_EN
    localparam int CNT_W = $clog2(NUM_EDGES + 1);

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_EDGES-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_EDGES; i++) begin
            n = n + CNT_W'(v[i]);
        end
        return n;
    endfunction

    // Counted from the merged value so the final obstacle's mask is included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blocked_cnt <= '0;
        end else if (enter_emit) begin
            blocked_cnt <= popcount(merged);
        end else if (done) begin
            blocked_cnt <= '0;
        end
    end
`endif

endmodule

// File: rtl/prm_edge_mask_collector.sv
// rtl/prm_edge_mask_collector.sv - registers obstacle codes for the edge-check array and ORs its masks per frame
// Optional blocked-edge popcount output under PRM_EDGE_CNT_EN.
module prm_edge_mask_collector
    import prm_edge_pkg::*;
#(
    parameter int NUM_EDGES = PRM_NUM_EDGES,
    parameter int CODE_W    = PRM_CODE_W,
    parameter int WORD_W    = PRM_WORD_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           obs_valid,
    output logic                           obs_ready,
    input  logic [CODE_W-1:0]              obs_code,
    input  logic                           obs_last,
    output logic [CODE_W-1:0]              chk_code,
    input  logic [NUM_EDGES-1:0]           edge_mask_vec,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WORD_W-1:0]              out_data,
    output logic                           out_last,
    output logic                           busy
`ifdef PRM_EDGE_CNT_EN
    ,
    output logic [$clog2(NUM_EDGES+1)-1:0] blocked_cnt
`endif
);

    logic pend_q;
    logic last_q;
    logic emitting;
    logic done;
    logic handshake;

    // Hold off new codes while the final code's mask is being sampled and during emit.
    assign obs_ready = !emitting && !(pend_q && last_q);
    assign handshake = obs_valid && obs_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_code <= '0;
            pend_q   <= 1'b0;
            last_q   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (handshake) begin
                chk_code <= obs_code;
                pend_q   <= 1'b1;
                last_q   <= obs_last;
                busy     <= 1'b1;
            end else begin
                pend_q <= 1'b0;
                last_q <= 1'b0;
                if (done) begin
                    busy <= 1'b0;
                end
            end
        end
    end

    prm_bitmap_serializer #(
        .NUM_EDGES (NUM_EDGES),
        .WORD_W    (WORD_W)
    ) u_serializer (
        .clk           (clk),
        .rst           (rst),
        .sample        (pend_q),
        .sample_last   (last_q),
        .edge_mask_vec (edge_mask_vec),
        .emitting      (emitting),
        .done          (done),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last)
`ifdef PRM_EDGE_CNT_EN
        ,
        .blocked_cnt   (blocked_cnt)
`endif
    );

endmodule
